add_round_key_stage: RTL and testbench
======================================

# add_round_key_stage

Pipeline stage directly downstream of the MixColumns stage in the AES datapath. It XORs the 128-bit state with the round key selected by the 4-bit header and registers the result. It also holds the 11 round keys, loaded in order from the key-expansion unit through a valid/ready handshake. The 132-bit header+state format is the same on input and output, so the output feeds the next round's SubBytes or the ciphertext sink.

## Interface
- NUM_KEYS, 11: number of round keys stored (rounds 0..10).
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- enable  in  1  pipeline advance; when low, the output register holds its value.
- data_in  in  132  [131:128] header, [127:0] state from MixColumns.
- data_out  out  132  [131:128] header, [127:0] state XOR round key; all zeros when the registered header is 0.
- key_valid  in  1  key-expansion unit presents a round key.
- key_data  in  128  round key, presented in index order 0..10.
- key_ready  out  1  stage accepts key_data this cycle.
- key_clear  in  1  discards all stored keys and restarts loading.
- keys_loaded  out  1  all NUM_KEYS keys are stored.
- drop_err  out  1  sticky flag: a valid block arrived while keys were not loaded, or arrived with an illegal header.

## Operation
- Header encoding:
  - 0: bubble.
  - 1..10: round number; uses key[header]. Header 10 is the final round, which bypassed MixColumns upstream.
  - 11: initial whitening; uses key[0].
  - 12..15: illegal.
- Key store FSM, with a 4-bit load counter cnt:
  - EMPTY: key_ready=1, cnt=0. key_valid moves the FSM to LOADING and writes key[0]; cnt becomes 1.
  - LOADING: key_ready=1. Each cycle with key_valid high writes key[cnt] and increments cnt. When the write at cnt=10 occurs, the FSM moves to READY.
  - READY: key_ready=0, keys_loaded=1. key_valid is ignored.
  - key_clear, from any state: go to EMPTY, cnt=0, keys_loaded=0. Stored key contents need not be zeroed.
  - key_clear and key_valid in the same cycle: clear wins and the key is not written.
- Datapath next-state, evaluated only when enable=1:
  - Header 0: next = 0.
  - Header 1..11 with keys_loaded=1: next = {header, state XOR key[sel]}.
  - Header 1..11 with keys_loaded=0: next = 0 (block dropped) and drop_err is set.
  - Header 12..15: next = 0 and drop_err is set.
- drop_err clears only on n_rst or key_clear.
- A key written in the same cycle a block is sampled is not used for that block. Selection always reads the stored array from before the write.

## Timing
- Reset values: data_out=0, key_ready=1, keys_loaded=0, drop_err=0, FSM=EMPTY, cnt=0.
- Latency: data_in sampled with enable=1 at edge N appears on data_out after edge N; one cycle.
- One block per cycle. There is no backpressure on the data path.
- enable=0: data_out holds its previous value, and drop_err does not change.
- keys_loaded rises in the cycle after the 11th key handshake. A block sampled at that same edge is dropped.
- key_clear asserted while READY: keys_loaded falls after the edge. Blocks sampled on or after that edge are dropped and flagged.
- Reset mid-load: the loading sequence restarts from key[0] after reset.
- All outputs are registered or decoded from state only; there is no combinational path from data_in to data_out.

## Structure
- Shared package aes_pkg holds:
  - typedef state_t as logic [127:0]; typedef header_t as logic [3:0].
  - constants HDR_BUBBLE=0, HDR_FINAL=10, HDR_INIT=11, NUM_ROUND_KEYS=11.
  - The same package is used by the SubBytes, ShiftRows and MixColumns stages.
- Sub-module round_key_store contains:
  - the key-load FSM, the counter and the 11x128 register array.
  - a combinational read port indexed by sel (header 11 maps to 0).
- The top level holds the header decode, the XOR, the output register and drop_err.

## Test plan
1. **Reset:** n_rst low, then release → data_out=0, key_ready=1, keys_loaded=0, drop_err=0.
2. **Whitening:**
   - Stimulus: load the FIPS-197 C.1 schedule, key[0]=000102030405060708090a0b0c0d0e0f; then send header 11 with state 00112233445566778899aabbccddeeff.
   - Required: one cycle later, data_out = {4'hB, 00102030405060708090a0b0c0d0e0f0}.
3. **Final round:** header 10 with an arbitrary state S → data_out = {4'hA, S XOR key[10]}, where key[10]=13111d7fe3944a17f307a78b4d2b30c5. Then header 0 → data_out all zeros.
4. **Keys not ready:**
   - Stimulus: load 5 keys, then send header 3.
   - Required: data_out=0 and drop_err=1.
   - Then load the remaining 6 keys and send header 3 → correct output, and drop_err stays 1.
5. **Clear races:**
   - key_clear together with key_valid while LOADING at cnt=4 → cnt=0, no write, key_ready=1.
   - key_clear in READY → keys_loaded falls after one edge, and drop_err=0.
6. **Hold and illegal header:**
   - enable=0 for 3 cycles with changing data_in → data_out constant.
   - Header 13 with enable=1 → data_out=0 and drop_err=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types, header codes and small helpers.
// Used by every round stage (SubBytes, ShiftRows, MixColumns, AddRoundKey).
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [3:0]   header_t;

   localparam header_t HDR_BUBBLE     = 4'd0;
   localparam header_t HDR_FINAL      = 4'd10;
   localparam header_t HDR_INIT       = 4'd11;
   localparam int      NUM_ROUND_KEYS = 11;

   typedef enum logic [1:0] {
      KS_EMPTY   = 2'd0,
      KS_LOADING = 2'd1,
      KS_READY   = 2'd2
   } key_state_e;

   // True for headers that carry a block needing a round key (1..11).
   function automatic logic hdr_is_round(input header_t hdr);
      return (hdr != HDR_BUBBLE) && (hdr <= HDR_INIT);
   endfunction

   // Initial whitening reuses key 0; rounds 1..10 index directly.
   function automatic header_t key_sel(input header_t hdr);
      return (hdr == HDR_INIT) ? HDR_BUBBLE : hdr;
   endfunction

endpackage

// File: rtl/round_key_store.sv
// Round-key register file with an in-order valid/ready load FSM.
// The read port is combinational and always returns the pre-write contents.
module round_key_store
   import aes_pkg::*;
#(
   parameter int NUM_KEYS = NUM_ROUND_KEYS
) (
   input  logic    clk,
   input  logic    n_rst,
   input  logic    key_valid,
   input  state_t  key_data,
   input  logic    key_clear,
   output logic    key_ready,
   output logic    keys_loaded,
   input  header_t sel,
   output state_t  rd_key
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

   key_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wr_en;
   state_t     keys_q [NUM_KEYS];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      if (key_clear) begin
         // Clear beats a simultaneous key handshake; that key is discarded.
         state_d = KS_EMPTY;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            KS_EMPTY, KS_LOADING: begin
               if (key_valid) begin
                  wr_en   = 1'b1;
                  cnt_d   = cnt_q + 4'd1;
                  state_d = (cnt_q == LAST_IDX) ? KS_READY : KS_LOADING;
               end
            end
            KS_READY: begin
               state_d = KS_READY;
            end
            default: begin
               state_d = KS_EMPTY;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= KS_EMPTY;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Key contents are deliberately not reset; the FSM gates their use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         keys_q[cnt_q] <= key_data;
      end
   end

   assign key_ready   = (state_q != KS_READY);
   assign keys_loaded = (state_q == KS_READY);

   always_comb begin
      rd_key = '0;
      if (sel <= LAST_IDX) begin
         rd_key = keys_q[sel];
      end
   end

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey pipeline stage: XORs the state with the header-selected round
// key and registers {header, result}; flags blocks that cannot be processed.
module add_round_key_stage
   import aes_pkg::*;
#(
   parameter int NUM_KEYS = NUM_ROUND_KEYS
) (
   input  logic           clk,
   input  logic           n_rst,
   input  logic           enable,
   input  logic [131:0]   data_in,
   output logic [131:0]   data_out,
   input  logic           key_valid,
   input  logic [127:0]   key_data,
   output logic           key_ready,
   input  logic           key_clear,
   output logic           keys_loaded,
   output logic           drop_err
);

   header_t      hdr;
   state_t       state_in;
   state_t       rd_key;
   logic         loaded_eff;
   logic [131:0] data_q, data_d;
   logic         drop_err_q, drop_err_d;

   assign hdr      = data_in[131:128];
   assign state_in = data_in[127:0];

   round_key_store #(
      .NUM_KEYS (NUM_KEYS)
   ) u_key_store (
      .clk         (clk),
      .n_rst       (n_rst),
      .key_valid   (key_valid),
      .key_data    (key_data),
      .key_clear   (key_clear),
      .key_ready   (key_ready),
      .keys_loaded (keys_loaded),
      .sel         (key_sel(hdr)),
      .rd_key      (rd_key)
   );

   // A clear landing on the same edge as a block invalidates the keys for it.
   assign loaded_eff = keys_loaded && !key_clear;

   always_comb begin
      data_d     = data_q;
      drop_err_d = drop_err_q;
      if (key_clear) begin
         drop_err_d = 1'b0;
      end
      if (enable) begin
         data_d = '0;
         if (hdr_is_round(hdr)) begin
            if (loaded_eff) begin
               data_d = {hdr, state_in ^ rd_key};
            end else begin
               drop_err_d = 1'b1;
            end
         end else if (hdr != HDR_BUBBLE) begin
            drop_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_q     <= '0;
         drop_err_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign data_out = data_q;
   assign drop_err = drop_err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: FIPS-197 vector table, hand-written corner
// sequences and a randomized phase checked against a key-count based model.
module tb_add_round_key_stage;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic         enable = 1'b0;
   logic [131:0] data_in = '0;
   logic [131:0] data_out;
   logic         key_valid = 1'b0;
   logic [127:0] key_data = '0;
   logic         key_ready;
   logic         key_clear = 1'b0;
   logic         keys_loaded;
   logic         drop_err;

   add_round_key_stage dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .enable      (enable),
      .data_in     (data_in),
      .data_out    (data_out),
      .key_valid   (key_valid),
      .key_data    (key_data),
      .key_ready   (key_ready),
      .key_clear   (key_clear),
      .keys_loaded (keys_loaded),
      .drop_err    (drop_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: how many keys are stored, what they are, sticky error.
   logic [127:0] m_keys [11];
   int           m_n;
   bit           m_err;
   logic [131:0] m_dout;

   logic [127:0] fips [11];

   typedef struct {
      logic [3:0]   hdr;
      logic [127:0] st;
      logic [131:0] exp;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data_out"}, data_out, m_dout);
      check({tag, ".key_ready"}, 132'(key_ready), 132'(m_n < 11));
      check({tag, ".keys_loaded"}, 132'(keys_loaded), 132'(m_n == 11));
      check({tag, ".drop_err"}, 132'(drop_err), 132'(m_err));
   endtask

   // One transaction: drive inputs, advance the model, clock, compare.
   task automatic step(input bit en, input logic [3:0] hdr, input logic [127:0] st,
                       input bit kv, input logic [127:0] kd, input bit clr, input string tag);
      bit   loaded;
      bit   drop;
      int   idx;
      enable    = en;
      data_in   = {hdr, st};
      key_valid = kv;
      key_data  = kd;
      key_clear = clr;
      loaded = (m_n == 11) && !clr;
      drop   = 1'b0;
      if (en) begin
         if (hdr == 4'd0) begin
            m_dout = '0;
         end else if (hdr <= 4'd11) begin
            idx = (hdr == 4'd11) ? 0 : int'(hdr);
            if (loaded) m_dout = {hdr, st ^ m_keys[idx]};
            else begin
               m_dout = '0;
               drop = 1'b1;
            end
         end else begin
            m_dout = '0;
            drop = 1'b1;
         end
      end
      if (clr) m_err = 1'b0;
      if (drop) m_err = 1'b1;
      if (clr) m_n = 0;
      else if (kv && m_n < 11) begin
         m_keys[m_n] = kd;
         m_n++;
      end
      @(posedge clk);
      #1;
      $display("[%0t] %s en=%0d hdr=%0d kv=%0d clr=%0d -> out=%h rdy=%0d ld=%0d err=%0d",
               $time, tag, en, hdr, kv, clr, data_out, key_ready, keys_loaded, drop_err);
      check_all(tag);
   endtask

   task automatic load_key(input logic [127:0] kd, input string tag);
      step(1'b1, 4'd0, '0, 1'b1, kd, 1'b0, tag);
   endtask

   task automatic do_reset(input string tag);
      n_rst = 1'b0;
      #2;
      m_n = 0;
      m_err = 1'b0;
      m_dout = '0;
      // Reset is asynchronous: outputs must already be cleared mid-cycle.
      check_all({tag, ".async"});
      enable = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      $display("[%0t] %s reset released", $time, tag);
      check_all(tag);
   endtask

   logic [127:0] s_a;
   logic [127:0] s_b;
   logic [131:0] held;

   initial begin
      fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      fips[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      fips[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      fips[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      fips[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      fips[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      fips[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      fips[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      fips[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      fips[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      fips[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

      s_a = 128'hdeadbeef0123456789abcdeffedcba98;
      s_b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      tbl[0] = '{4'd11, 128'h00112233445566778899aabbccddeeff,
                 {4'hB, 128'h00102030405060708090a0b0c0d0e0f0}};
      tbl[1] = '{4'd10, s_a, {4'hA, s_a ^ 128'h13111d7fe3944a17f307a78b4d2b30c5}};
      tbl[2] = '{4'd0,  s_a, 132'h0};
      tbl[3] = '{4'd1,  s_b, {4'h1, s_b ^ 128'hd6aa74fdd2af72fadaa678f1d6ab76fe}};
      tbl[4] = '{4'd5,  s_b, {4'h5, s_b ^ 128'h3caaa3e8a99f9deb50f3af57adf622aa}};
      tbl[5] = '{4'd9,  s_a, {4'h9, s_a ^ 128'h549932d1f08557681093ed9cbe2c974e}};

      do_reset("reset");

      // Partial load: block is dropped and flagged.
      for (int i = 0; i < 5; i++) load_key(fips[i], "load5");
      step(1'b1, 4'd3, s_a, 1'b0, '0, 1'b0, "early_hdr3");
      check("early_hdr3.out_zero", data_out, 132'h0);
      check("early_hdr3.err", 132'(drop_err), 132'h1);
      for (int i = 5; i < 11; i++) load_key(fips[i], "load_rest");
      step(1'b1, 4'd3, s_a, 1'b0, '0, 1'b0, "late_hdr3");
      check("late_hdr3.out", data_out, {4'h3, s_a ^ fips[3]});
      check("late_hdr3.err_sticky", 132'(drop_err), 132'h1);

      // FIPS-197 table.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, tbl[i].hdr, tbl[i].st, 1'b0, '0, 1'b0, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d.expected", i), data_out, tbl[i].exp);
      end

      // Hold for three cycles with changing input.
      held = data_out;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
              1'b0, '0, 1'b0, "hold");
         check("hold.const", data_out, held);
      end

      // Illegal header after a clear of the error via a full clear/reload is
      // exercised below; here error is already set, so clear first.
      step(1'b1, 4'd0, '0, 1'b0, '0, 1'b1, "clear_ready");
      check("clear_ready.ld", 132'(keys_loaded), 132'h0);
      check("clear_ready.err", 132'(drop_err), 132'h0);

      // Clear racing a key handshake at cnt=4.
      for (int i = 0; i < 4; i++) load_key({$urandom, $urandom, $urandom, $urandom}, "reload4");
      step(1'b1, 4'd0, '0, 1'b1, 128'hffff, 1'b1, "clear_race");
      check("clear_race.rdy", 132'(key_ready), 132'h1);
      for (int i = 0; i < 10; i++) load_key(fips[i], "reload");
      check("reload10.not_loaded", 132'(keys_loaded), 132'h0);
      // Block sampled at the 11th handshake edge is dropped.
      step(1'b1, 4'd5, s_b, 1'b1, fips[10], 1'b0, "last_key_blk");
      check("last_key_blk.out", data_out, 132'h0);
      check("last_key_blk.err", 132'(drop_err), 132'h1);
      step(1'b1, 4'd5, s_b, 1'b0, '0, 1'b0, "after_load");
      check("after_load.out", data_out, {4'h5, s_b ^ fips[5]});

      // Illegal header from a clean error state.
      do_reset("reset2");
      for (int i = 0; i < 11; i++) load_key(fips[i], "load_all");
      step(1'b1, 4'd13, s_a, 1'b0, '0, 1'b0, "illegal13");
      check("illegal13.out", data_out, 132'h0);
      check("illegal13.err", 132'(drop_err), 132'h1);

      // Block on the clear edge is dropped and flagged.
      step(1'b1, 4'd2, s_a, 1'b0, '0, 1'b1, "clear_with_blk");
      check("clear_with_blk.err", 132'(drop_err), 132'h1);

      // Reset mid-load restarts from key 0.
      for (int i = 0; i < 3; i++) load_key({$urandom, $urandom, $urandom, $urandom}, "preload");
      do_reset("reset_mid");
      for (int i = 0; i < 11; i++) load_key(fips[10 - i], "load_rev");
      step(1'b1, 4'd11, s_a, 1'b0, '0, 1'b0, "rev_whiten");
      check("rev_whiten.out", data_out, {4'hB, s_a ^ fips[10]});

      // Randomized phase against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)),
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 1) == 1,
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 39) == 0,
              "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
